// File: rtl/call_stack.sv
`default_nettype none
// ============================================================================
// call_stack : hardware return-address stack feeding the PC load port.
// Revision   : 1.0
// ============================================================================
module call_stack #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         push_addr,
    output logic [WIDTH-1:0]         ret_addr,
    output logic                     ret_valid,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);
    localparam logic [CW-1:0] C_ONE   = CW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [CW-1:0]    count_q,     count_d;
    logic [WIDTH-1:0] ret_addr_q,  ret_addr_d;
    logic             ret_valid_q, ret_valid_d;
    logic             overflow_q,  overflow_d;
    logic             underflow_q, underflow_d;

    logic             w_empty;
    logic             w_full;
    logic [CW-1:0]    w_count_m1;
    logic [AW-1:0]    w_top_idx;
    logic [AW-1:0]    w_push_idx;
    logic             w_mem_we;
    logic [AW-1:0]    w_mem_widx;

    assign w_empty    = (count_q == '0);
    assign w_full     = (count_q == C_DEPTH);
    assign w_count_m1 = count_q - C_ONE;
    assign w_top_idx  = w_count_m1[AW-1:0];
    assign w_push_idx = count_q[AW-1:0];

    always_comb begin
        count_d     = count_q;
        ret_addr_d  = ret_addr_q;
        ret_valid_d = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        w_mem_we    = 1'b0;
        w_mem_widx  = w_push_idx;

        if (pop && !w_empty) begin
            ret_addr_d  = mem_q[w_top_idx];
            ret_valid_d = 1'b1;
            if (push) begin
                // Swap: the new address replaces the popped top, depth unchanged.
                w_mem_we   = 1'b1;
                w_mem_widx = w_top_idx;
            end else begin
                count_d = w_count_m1;
            end
        end else begin
            if (pop) begin
                underflow_d = 1'b1;
            end
            if (push) begin
                if (w_full) begin
                    overflow_d = 1'b1;
                end else begin
                    w_mem_we = 1'b1;
                    count_d  = count_q + C_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q     <= '0;
            ret_addr_q  <= '0;
            ret_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            ret_addr_q  <= ret_addr_d;
            ret_valid_q <= ret_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            mem_q[w_mem_widx] <= push_addr;
        end
    end

    assign ret_addr  = ret_addr_q;
    assign ret_valid = ret_valid_q;
    assign count     = count_q;
    assign empty     = w_empty;
    assign full      = w_full;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_call_stack.sv
`default_nettype none
// ============================================================================
// tb_call_stack : vector table, directed corner cases and a random run
// against a queue-based return-stack model.
// ============================================================================
module tb_call_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             push = 1'b0;
    logic             pop = 1'b0;
    logic [WIDTH-1:0] push_addr = '0;
    logic [WIDTH-1:0] ret_addr;
    logic             ret_valid;
    logic [3:0]       count;
    logic             empty, full, overflow, underflow;

    int checks = 0;
    int errors = 0;

    call_stack #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .push(push), .pop(pop), .push_addr(push_addr),
        .ret_addr(ret_addr), .ret_valid(ret_valid), .count(count),
        .empty(empty), .full(full), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    // Simple program counter loaded from the stack.
    logic [WIDTH-1:0] pc_o;
    always @(posedge clk or posedge rst) begin
        if (rst) pc_o <= '0;
        else if (ret_valid) pc_o <= ret_addr;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic pu, input logic po, input logic [WIDTH-1:0] a);
        push = pu; pop = po; push_addr = a;
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0;
    endtask

    task automatic do_reset();
        push = 1'b1; push_addr = 16'h1234;
        rst = 1'b1;
        #10;
        chk("rst_count", 32'(count), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_valid", 32'(ret_valid), 0);
        chk("rst_addr", 32'(ret_addr), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_unf", 32'(underflow), 0);
        rst = 1'b0; push = 1'b0;
    endtask

    task automatic chk_state(input string tag, input int c, input logic v,
                             input logic [WIDTH-1:0] ra, input logic ov, input logic un);
        chk({tag, "_count"}, 32'(count), 32'(c));
        chk({tag, "_valid"}, 32'(ret_valid), 32'(v));
        chk({tag, "_addr"}, 32'(ret_addr), 32'(ra));
        chk({tag, "_empty"}, 32'(empty), 32'(c == 0));
        chk({tag, "_full"}, 32'(full), 32'(c == DEPTH));
        chk({tag, "_ovf"}, 32'(overflow), 32'(ov));
        chk({tag, "_unf"}, 32'(underflow), 32'(un));
    endtask

    typedef struct {
        logic             pu;
        logic             po;
        logic [WIDTH-1:0] a;
        int               c;
        logic             v;
        logic [WIDTH-1:0] ra;
        logic             un;
    } vec_t;

    vec_t vecs[15];

    // Random-phase reference model.
    logic [WIDTH-1:0] m_stack[$];
    logic [WIDTH-1:0] m_ret;
    logic             m_valid, m_ovf, m_unf;

    initial begin
        // Starts straight from reset: underflow, LIFO order, swap, push+pop on empty.
        vecs[0]  = '{1'b0, 1'b1, 16'h0000, 0, 1'b0, 16'h0000, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 16'h00AA, 1, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h00AA, 1'b1};
        vecs[3]  = '{1'b1, 1'b0, 16'h0011, 1, 1'b0, 16'h00AA, 1'b1};
        vecs[4]  = '{1'b1, 1'b0, 16'h0022, 2, 1'b0, 16'h00AA, 1'b1};
        vecs[5]  = '{1'b1, 1'b0, 16'h0033, 3, 1'b0, 16'h00AA, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 2, 1'b1, 16'h0033, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 16'h0000, 1, 1'b1, 16'h0022, 1'b1};
        vecs[8]  = '{1'b0, 1'b0, 16'h0000, 1, 1'b0, 16'h0022, 1'b1};
        vecs[9]  = '{1'b1, 1'b0, 16'h0022, 2, 1'b0, 16'h0022, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 16'h0099, 2, 1'b1, 16'h0022, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 16'h0000, 1, 1'b1, 16'h0099, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h0011, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 16'h0055, 1, 1'b0, 16'h0011, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 16'h0000, 0, 1'b1, 16'h0055, 1'b1};

        #1;
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < 15; i++) begin
            step(vecs[i].pu, vecs[i].po, vecs[i].a);
            chk_state($sformatf("vec%0d", i), vecs[i].c, vecs[i].v, vecs[i].ra, 1'b0, vecs[i].un);
        end

        // Fill to full, overflow, then pop must return the last accepted push.
        do_reset();
        @(posedge clk); #1;
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 16'h0100 + 16'(i));
            chk("fill_count", 32'(count), 32'(i + 1));
        end
        chk("fill_full", 32'(full), 1);
        step(1'b1, 1'b0, 16'h0FFF);
        chk_state("ovf", DEPTH, 1'b0, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h0ABC);
        chk_state("swapfull", DEPTH, 1'b1, 16'h0107, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0000);
        chk_state("popfull", DEPTH - 1, 1'b1, 16'h0ABC, 1'b1, 1'b0);
        step(1'b0, 1'b1, 16'h0000);
        chk("popfull2_addr", 32'(ret_addr), 32'h0106);

        // PC integration and asynchronous reset during a return strobe.
        do_reset();
        @(posedge clk); #1;
        step(1'b0, 1'b1, 16'h0000);
        step(1'b1, 1'b0, 16'h00FF);
        step(1'b0, 1'b1, 16'h0000);
        chk("pc_strobe", 32'(ret_valid), 1);
        step(1'b0, 1'b0, 16'h0000);
        chk("pc_load", 32'(pc_o), 32'h00FF);
        step(1'b1, 1'b0, 16'h0EEE);
        step(1'b0, 1'b1, 16'h0000);
        chk("mid_valid_pre", 32'(ret_valid), 1);
        chk("mid_unf_pre", 32'(underflow), 1);
        rst = 1'b1;
        #1;
        chk("mid_valid", 32'(ret_valid), 0);
        chk("mid_count", 32'(count), 0);
        chk("mid_ovf", 32'(overflow), 0);
        chk("mid_unf", 32'(underflow), 0);
        #9;
        rst = 1'b0;

        // Random run against the queue model.
        do_reset();
        m_stack.delete();
        m_ret = '0; m_valid = 1'b0; m_ovf = 1'b0; m_unf = 1'b0;
        @(posedge clk); #1;
        for (int n = 0; n < 600; n++) begin
            logic pu, po;
            logic [WIDTH-1:0] a;
            pu = ($urandom_range(0, 99) < 55);
            po = ($urandom_range(0, 99) < 45);
            a  = WIDTH'($urandom);
            m_valid = 1'b0;
            if (po) begin
                if (m_stack.size() == 0) begin
                    m_unf = 1'b1;
                    if (pu) m_stack.push_back(a);
                end else begin
                    m_ret = m_stack.pop_back();
                    m_valid = 1'b1;
                    if (pu) m_stack.push_back(a);
                end
            end else if (pu) begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else m_stack.push_back(a);
            end
            step(pu, po, a);
            chk_state($sformatf("rnd%0d", n), m_stack.size(), m_valid, m_ret, m_ovf, m_unf);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
